// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: FSM state encodings and bus_size codes for the memory port arbiter
package mem_port_arbiter_pkg;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        I_ADDR = 3'd1,
        I_WAIT = 3'd2,
        D_ADDR = 3'd3,
        D_WAIT = 3'd4
    } arb_state_e;
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: SRAM-like bus between the arbiter (master) and memory (slave)
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              bus_req;
    logic              bus_wr;
    logic [1:0]        bus_size;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_addr_ok;
    logic              bus_data_ok;
    logic [DATA_W-1:0] bus_rdata;
    modport master (
        output bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata
    );
    modport slave (
        input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata
    );
endinterface

// File: rtl/mem_port_arbiter_size_enc.sv
// mem_size_enc: byte enables to bus_size, reads forced to aligned word access
module mem_size_enc
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [3:0]        wen,
    input  logic [ADDR_W-1:0] addr_in,
    output logic [1:0]        size,
    output logic [ADDR_W-1:0] addr_out
);
    always_comb begin
        size     = (wen == 4'b0011 || wen == 4'b1100) ? SZ_HALF : $onehot(wen) ? SZ_BYTE : SZ_WORD;
        addr_out = (wen == 4'b0000) ? {addr_in[ADDR_W-1:2], 2'b00} : addr_in;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory bus between fetch and data ports; ARB_STATS_EN adds stat counters
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
`ifdef ARB_STATS_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_en,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_en,
    input  logic [3:0]        data_wen,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    input  logic              all_stall,
    output logic              i_stall,
    output logic              d_stall,
    mem_port_arbiter_if.master bus
`ifdef ARB_STATS_EN
    , output logic [CNT_W-1:0] stat_i_cnt
    , output logic [CNT_W-1:0] stat_d_cnt
    , output logic [CNT_W-1:0] stat_wait_cnt
`endif
);
    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_q, wr_d;
    logic [1:0]        size_q, size_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
    logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
    logic              i_done_q, i_done_d;
    logic              d_done_q, d_done_d;
    logic              i_fin, d_fin, i_take, d_take;
    logic [1:0]        enc_size;
    logic [ADDR_W-1:0] enc_addr;

    mem_size_enc #(.ADDR_W(ADDR_W)) u_size_enc (
        .wen     (data_wen),
        .addr_in (data_addr),
        .size    (enc_size),
        .addr_out(enc_addr)
    );

    always_comb begin
        i_fin        = (state_q == I_ADDR && bus.bus_addr_ok && bus.bus_data_ok) || (state_q == I_WAIT && bus.bus_data_ok);
        d_fin        = (state_q == D_ADDR && bus.bus_addr_ok && bus.bus_data_ok) || (state_q == D_WAIT && bus.bus_data_ok);
        // a flushed requester lets the bus transaction finish but drops its data
        i_take       = i_fin && inst_en;
        d_take       = d_fin && data_en;
        state_d      = state_q;
        addr_d       = addr_q;
        wr_d         = wr_q;
        size_d       = size_q;
        wdata_d      = wdata_q;
        case (state_q)
            IDLE: begin
                if (data_en && !d_done_q) begin
                    state_d = D_ADDR;
                    addr_d  = enc_addr;
                    wr_d    = |data_wen;
                    size_d  = enc_size;
                    wdata_d = data_wdata;
                end else if (inst_en && !i_done_q) begin
                    state_d = I_ADDR;
                    addr_d  = inst_addr;
                    wr_d    = 1'b0;
                    size_d  = SZ_WORD;
                    wdata_d = '0;
                end
            end
            I_ADDR:  state_d = i_fin ? IDLE : bus.bus_addr_ok ? I_WAIT : I_ADDR;
            I_WAIT:  state_d = i_fin ? IDLE : I_WAIT;
            D_ADDR:  state_d = d_fin ? IDLE : bus.bus_addr_ok ? D_WAIT : D_ADDR;
            D_WAIT:  state_d = d_fin ? IDLE : D_WAIT;
            default: state_d = IDLE;
        endcase
        inst_rdata_d = i_take ? bus.bus_rdata : inst_rdata_q;
        data_rdata_d = d_take ? bus.bus_rdata : data_rdata_q;
        i_done_d     = i_take || (i_done_q && all_stall);
        d_done_d     = d_take || (d_done_q && all_stall);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wr_q         <= 1'b0;
            size_q       <= '0;
            wdata_q      <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
            i_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wr_q         <= wr_d;
            size_q       <= size_d;
            wdata_q      <= wdata_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            i_done_q     <= i_done_d;
            d_done_q     <= d_done_d;
        end
    end

    assign bus.bus_req   = (state_q == I_ADDR) || (state_q == D_ADDR);
    assign bus.bus_wr    = wr_q;
    assign bus.bus_size  = size_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;
    assign inst_rdata    = inst_rdata_q;
    assign data_rdata    = data_rdata_q;
    assign i_stall       = inst_en & ~i_done_q;
    assign d_stall       = data_en & ~d_done_q;

`ifdef ARB_STATS_EN
    logic [CNT_W-1:0] stat_i_q, stat_i_d, stat_d_q, stat_d_d, stat_w_q, stat_w_d;
    always_comb begin
        stat_i_d = stat_i_q + CNT_W'(i_take);
        stat_d_d = stat_d_q + CNT_W'(d_take);
        stat_w_d = stat_w_q + CNT_W'(i_stall | d_stall);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_i_q <= '0;
            stat_d_q <= '0;
            stat_w_q <= '0;
        end else begin
            stat_i_q <= stat_i_d;
            stat_d_q <= stat_d_d;
            stat_w_q <= stat_w_d;
        end
    end
    assign stat_i_cnt    = stat_i_q;
    assign stat_d_cnt    = stat_d_q;
    assign stat_wait_cnt = stat_w_q;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, sizing, stall hold, flush and reset
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_en = 1'b0;
    logic [31:0] inst_addr = '0;
    logic [31:0] inst_rdata;
    logic        data_en = 1'b0;
    logic [3:0]  data_wen = '0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic [31:0] data_rdata;
    logic        all_stall = 1'b1;
    logic        i_stall, d_stall;
    int          n_chk = 0;
    int          n_fail = 0;
`ifdef ARB_STATS_EN
    logic [31:0] stat_i_cnt, stat_d_cnt, stat_wait_cnt;
`endif

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

    mem_port_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .inst_en   (inst_en),
        .inst_addr (inst_addr),
        .inst_rdata(inst_rdata),
        .data_en   (data_en),
        .data_wen  (data_wen),
        .data_addr (data_addr),
        .data_wdata(data_wdata),
        .data_rdata(data_rdata),
        .all_stall (all_stall),
        .i_stall   (i_stall),
        .d_stall   (d_stall),
        .bus       (bus_if.master)
`ifdef ARB_STATS_EN
        , .stat_i_cnt   (stat_i_cnt)
        , .stat_d_cnt   (stat_d_cnt)
        , .stat_wait_cnt(stat_wait_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_drive(input logic a_ok, input logic d_ok, input logic [31:0] rd);
        bus_if.bus_addr_ok = a_ok;
        bus_if.bus_data_ok = d_ok;
        bus_if.bus_rdata   = rd;
    endtask

    initial begin
        bus_drive(1'b0, 1'b0, 32'h0);
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("rst_req", 32'(bus_if.bus_req), 32'd0);
        chk("rst_addr", bus_if.bus_addr, 32'h0);
        chk("rst_size", 32'(bus_if.bus_size), 32'd0);
        chk("rst_wr", 32'(bus_if.bus_wr), 32'd0);
        chk("rst_istall", 32'(i_stall), 32'd0);
        chk("rst_irdata", inst_rdata, 32'h0);
        // fetch with one-cycle addr_ok and data_ok
        tick();
        inst_en = 1'b1; inst_addr = 32'hBFC00000; #1;
        chk("t1_istall_c1", 32'(i_stall), 32'd1);
        chk("t1_req_c1", 32'(bus_if.bus_req), 32'd0);
        tick();
        bus_drive(1'b1, 1'b0, 32'h0); #1;
        chk("t1_req", 32'(bus_if.bus_req), 32'd1);
        chk("t1_addr", bus_if.bus_addr, 32'hBFC00000);
        chk("t1_size", 32'(bus_if.bus_size), 32'd2);
        chk("t1_wr", 32'(bus_if.bus_wr), 32'd0);
        chk("t1_istall_c2", 32'(i_stall), 32'd1);
        tick();
        bus_drive(1'b0, 1'b1, 32'h3C1DBFC0); #1;
        chk("t1_req_wait", 32'(bus_if.bus_req), 32'd0);
        chk("t1_istall_c3", 32'(i_stall), 32'd1);
        tick();
        bus_drive(1'b0, 1'b0, 32'hDEADBEEF); all_stall = 1'b0; #1;
        chk("t1_istall_done", 32'(i_stall), 32'd0);
        chk("t1_irdata", inst_rdata, 32'h3C1DBFC0);
        tick();
        inst_en = 1'b0; all_stall = 1'b1; #1;
        chk("t1_req_idle", 32'(bus_if.bus_req), 32'd0);
        // simultaneous fetch and data read: data wins
        tick();
        inst_en = 1'b1; inst_addr = 32'hBFC00004;
        data_en = 1'b1; data_wen = 4'b0000; data_addr = 32'h80001004; #1;
        chk("t2_istall", 32'(i_stall), 32'd1);
        chk("t2_dstall", 32'(d_stall), 32'd1);
        tick();
        bus_drive(1'b1, 1'b0, 32'h0); #1;
        chk("t2_d_req", 32'(bus_if.bus_req), 32'd1);
        chk("t2_d_addr", bus_if.bus_addr, 32'h80001004);
        chk("t2_d_wr", 32'(bus_if.bus_wr), 32'd0);
        tick();
        bus_drive(1'b0, 1'b1, 32'h11112222); #1;
        chk("t2_dstall_wait", 32'(d_stall), 32'd1);
        tick();
        bus_drive(1'b0, 1'b0, 32'h0); #1;
        chk("t2_dstall_done", 32'(d_stall), 32'd0);
        chk("t2_istall_still", 32'(i_stall), 32'd1);
        chk("t2_drdata", data_rdata, 32'h11112222);
        tick();
        bus_drive(1'b1, 1'b0, 32'h0); #1;
        chk("t2_i_req", 32'(bus_if.bus_req), 32'd1);
        chk("t2_i_addr", bus_if.bus_addr, 32'hBFC00004);
        tick();
        bus_drive(1'b0, 1'b1, 32'h33334444); #1;
        chk("t2_istall_wait", 32'(i_stall), 32'd1);
        tick();
        bus_drive(1'b0, 1'b0, 32'h0); all_stall = 1'b0; #1;
        chk("t2_istall_done", 32'(i_stall), 32'd0);
        chk("t2_irdata", inst_rdata, 32'h33334444);
        chk("t2_drdata_hold", data_rdata, 32'h11112222);
        tick();
        inst_en = 1'b0; data_en = 1'b0; all_stall = 1'b1; #1;
        // sized writes and aligned read
        tick();
        data_en = 1'b1; data_wen = 4'b1100; data_addr = 32'h80000002; data_wdata = 32'hAABBCCDD; #1;
        chk("t3_dstall", 32'(d_stall), 32'd1);
        tick();
        bus_drive(1'b1, 1'b1, 32'h0); #1;
        chk("t3_h_req", 32'(bus_if.bus_req), 32'd1);
        chk("t3_h_wr", 32'(bus_if.bus_wr), 32'd1);
        chk("t3_h_size", 32'(bus_if.bus_size), 32'd1);
        chk("t3_h_addr", bus_if.bus_addr, 32'h80000002);
        chk("t3_h_wdata", bus_if.bus_wdata, 32'hAABBCCDD);
        tick();
        bus_drive(1'b0, 1'b0, 32'h0); all_stall = 1'b0;
        data_wen = 4'b0010; data_addr = 32'h80000003; #1;
        chk("t3_h_done", 32'(d_stall), 32'd0);
        chk("t3_h_req_idle", 32'(bus_if.bus_req), 32'd0);
        tick();
        all_stall = 1'b1; #1;
        chk("t3_b_dstall", 32'(d_stall), 32'd1);
        tick();
        bus_drive(1'b1, 1'b0, 32'h0); #1;
        chk("t3_b_size", 32'(bus_if.bus_size), 32'd0);
        chk("t3_b_wr", 32'(bus_if.bus_wr), 32'd1);
        chk("t3_b_addr", bus_if.bus_addr, 32'h80000003);
        tick();
        bus_drive(1'b0, 1'b1, 32'h0); #1;
        tick();
        bus_drive(1'b0, 1'b0, 32'h0); all_stall = 1'b0;
        data_wen = 4'b0000; data_addr = 32'h80000007; #1;
        chk("t3_b_done", 32'(d_stall), 32'd0);
        tick();
        all_stall = 1'b1; #1;
        tick();
        bus_drive(1'b1, 1'b1, 32'h55667788); #1;
        chk("t3_r_addr", bus_if.bus_addr, 32'h80000004);
        chk("t3_r_size", 32'(bus_if.bus_size), 32'd2);
        chk("t3_r_wr", 32'(bus_if.bus_wr), 32'd0);
        tick();
        bus_drive(1'b0, 1'b0, 32'h0); #1;
        chk("t3_r_rdata", data_rdata, 32'h55667788);
        chk("t3_r_done", 32'(d_stall), 32'd0);
        data_en = 1'b0; all_stall = 1'b0;
        tick();
        all_stall = 1'b1; #1;
        // hold with all_stall after fetch completes
        tick();
        inst_en = 1'b1; inst_addr = 32'hBFC00008; #1;
        tick();
        bus_drive(1'b1, 1'b0, 32'h0); #1;
        tick();
        bus_drive(1'b0, 1'b1, 32'h99990000); #1;
        tick();
        bus_drive(1'b0, 1'b0, 32'hFFFFFFFF); #1;
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_rdata", inst_rdata, 32'h99990000);
            chk("t4_hold_req", 32'(bus_if.bus_req), 32'd0);
            chk("t4_hold_istall", 32'(i_stall), 32'd0);
            if (i == 4) all_stall = 1'b0;
            tick();
        end
        chk("t4_clear_istall", 32'(i_stall), 32'd1);
        chk("t4_clear_rdata", inst_rdata, 32'h99990000);
        inst_en = 1'b0; all_stall = 1'b1; #1;
        tick();
        chk("t4_no_req", 32'(bus_if.bus_req), 32'd0);
        // flush during I_WAIT
        inst_en = 1'b1; inst_addr = 32'hBFC0000C; #1;
        tick();
        bus_drive(1'b1, 1'b0, 32'h0); #1;
        chk("t5_req", 32'(bus_if.bus_req), 32'd1);
        tick();
        bus_drive(1'b0, 1'b1, 32'h12345678); inst_en = 1'b0; #1;
        chk("t5_flush_istall", 32'(i_stall), 32'd0);
        tick();
        bus_drive(1'b0, 1'b0, 32'h0); inst_en = 1'b1; inst_addr = 32'hBFC00010; #1;
        chk("t5_discard", inst_rdata, 32'h99990000);
        chk("t5_not_done", 32'(i_stall), 32'd1);
        chk("t5_idle_req", 32'(bus_if.bus_req), 32'd0);
        tick();
        bus_drive(1'b1, 1'b1, 32'h0A0B0C0D); #1;
        chk("t5_refetch_req", 32'(bus_if.bus_req), 32'd1);
        chk("t5_refetch_addr", bus_if.bus_addr, 32'hBFC00010);
        tick();
        bus_drive(1'b0, 1'b0, 32'h0); #1;
        chk("t5_rdata", inst_rdata, 32'h0A0B0C0D);
        chk("t5_done", 32'(i_stall), 32'd0);
        inst_en = 1'b0; all_stall = 1'b0;
        tick();
        all_stall = 1'b1; #1;
`ifdef ARB_STATS_EN
        chk("st_i_cnt", stat_i_cnt, 32'd4);
        chk("st_d_cnt", stat_d_cnt, 32'd4);
`endif
        // reset in D_WAIT, late data_ok ignored
        tick();
        data_en = 1'b1; data_wen = 4'b0000; data_addr = 32'h80002000; #1;
        tick();
        bus_drive(1'b1, 1'b0, 32'h0); #1;
        tick();
        bus_drive(1'b0, 1'b0, 32'h0); rst = 1'b1; #1;
        chk("t6_wait_req", 32'(bus_if.bus_req), 32'd0);
        tick();
        rst = 1'b0; bus_drive(1'b0, 1'b1, 32'h77777777); #1;
        chk("t6_req", 32'(bus_if.bus_req), 32'd0);
        chk("t6_addr", bus_if.bus_addr, 32'h0);
        chk("t6_drdata", data_rdata, 32'h0);
        chk("t6_dstall", 32'(d_stall), 32'd1);
        chk("t6_irdata", inst_rdata, 32'h0);
`ifdef ARB_STATS_EN
        chk("t6_st_i", stat_i_cnt, 32'd0);
        chk("t6_st_d", stat_d_cnt, 32'd0);
        chk("t6_st_w", stat_wait_cnt, 32'd0);
`endif
        tick();
        bus_drive(1'b0, 1'b0, 32'h0); #1;
        chk("t6_reissue_req", 32'(bus_if.bus_req), 32'd1);
        chk("t6_late_ignored", data_rdata, 32'h0);
        data_en = 1'b0;
        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
